stream_parity_checker: RTL

STREAM_PARITY_CHECKER -- requirements
Module: stream_parity_checker

---
 rtl/parity_pkg.sv | 12 +
 rtl/lane_parity.sv | 16 +
 rtl/stream_parity_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared parity definitions: mode encoding for odd_mode and the lane-count
// derivation used by the stream parity checker and its lane slices.
package parity_pkg;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int num_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/lane_parity.sv
// Parity check of a single lane: flags an error when the lane bits plus its
// parity bit do not match the selected even/odd parity mode.
module lane_parity
    import parity_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] data,
    input  logic              parity,
    input  logic              odd_mode,
    output logic              err
);

    assign err = (^data) ^ parity ^ (odd_mode == PARITY_ODD);

endmodule

// File: rtl/stream_parity_checker.sv
// Valid/ready stream stage that checks per-lane parity and registers the word
// with its error flags. Define PARITY_ERR_CNT_EN to build the err_cnt counter.
module stream_parity_checker
    import parity_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  LANE_W    = 8,
    parameter int  CNT_W     = 16,
    localparam int NUM_LANES = num_lanes(DATA_W, LANE_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 odd_mode,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [NUM_LANES-1:0] in_parity,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [NUM_LANES-1:0] out_lane_err,
    output logic                 out_err,
    output logic                 sticky_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]     err_cnt
`endif
);

    logic                 out_valid_reg;
    logic [DATA_W-1:0]    out_data_reg;
    logic [NUM_LANES-1:0] lane_err_reg;
    logic                 out_err_reg;
    logic                 sticky_reg;
    logic [NUM_LANES-1:0] lane_err_next;
    logic                 accept;
    logic                 word_err;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_parity #(
            .LANE_W(LANE_W)
        ) u_lane (
            .data    (in_data[gi*LANE_W +: LANE_W]),
            .parity  (in_parity[gi]),
            .odd_mode(odd_mode),
            .err     (lane_err_next[gi])
        );
    end

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign word_err = |lane_err_next;

    // Flags are captured with the word, so odd_mode changes while stalled
    // cannot disturb the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            lane_err_reg  <= '0;
            out_err_reg   <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data;
            lane_err_reg  <= lane_err_next;
            out_err_reg   <= word_err;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // An errored acceptance outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (accept && word_err) begin
            sticky_reg <= 1'b1;
        end else if (clr) begin
            sticky_reg <= 1'b0;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (accept && word_err) begin
            if (clr) begin
                cnt_reg <= CNT_W'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else if (clr) begin
            cnt_reg <= '0;
        end
    end

    assign err_cnt = cnt_reg;
`else
    // Without the counter CNT_W has no hardware; this empty guard keeps it referenced.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_lane_err = lane_err_reg;
    assign out_err      = out_err_reg;
    assign sticky_err   = sticky_reg;

endmodule
